// File: rtl/qpu_pkg.sv
// rtl/qpu_pkg.sv - shared constants, shift-width helper and request type for the normalize path
package qpu_pkg;

  localparam int QPU_WORK_WIDTH = 32;
  localparam int QPU_EXP_WIDTH  = 8;
  localparam int QPU_GUARD_BITS = 8;

  // Width of a right-shift amount able to express 0..work_width
  function automatic int shift_width(input int work_width);
    return $clog2(work_width) + 1;
  endfunction

  // Value/exponent pair handed between the normalize stages
  typedef struct packed {
    logic [QPU_WORK_WIDTH-1:0] val;
    logic [QPU_EXP_WIDTH-1:0]  exp;
  } norm_req_t;

endpackage

// File: rtl/lead_sign_count.sv
// rtl/lead_sign_count.sv - combinational redundant-sign-bit counter
module lead_sign_count #(
  parameter int WORK_WIDTH = 32
) (
  input  logic [WORK_WIDTH-1:0]         val_i,
  output logic [$clog2(WORK_WIDTH)-1:0] rsb_o
);

  localparam int RW = $clog2(WORK_WIDTH);

  logic run;

  // Walk down from just below the MSB while bits still match the sign
  always_comb begin
    rsb_o = '0;
    run   = 1'b1;
    for (int i = WORK_WIDTH - 2; i >= 0; i--) begin
      if (run) begin
        if (val_i[i] == val_i[WORK_WIDTH-1]) begin
          rsb_o = rsb_o + RW'(1);
        end else begin
          run = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/norm_shift_calc.sv
// rtl/norm_shift_calc.sv - two-stage sign-headroom shift and exponent adjust; NORM_SHIFT_STATS_EN adds counters
module norm_shift_calc
  import qpu_pkg::*;
#(
  parameter int WORK_WIDTH = QPU_WORK_WIDTH,
  parameter int EXP_WIDTH  = QPU_EXP_WIDTH,
  parameter int GUARD_BITS = QPU_GUARD_BITS
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [WORK_WIDTH-1:0]               in_val,
  input  logic [EXP_WIDTH-1:0]                in_exp,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [WORK_WIDTH-1:0]               val_q,
  output logic [shift_width(WORK_WIDTH)-1:0]  shift_amt_q,
  output logic [EXP_WIDTH-1:0]                exp_q,
  output logic                                exp_sat_q
`ifdef NORM_SHIFT_STATS_EN
  ,
  input  logic                                stat_clr,
  output logic [31:0]                         stat_samples,
  output logic [31:0]                         stat_shifted,
  output logic [15:0]                         stat_exp_sat
`endif
);

  localparam int SW = shift_width(WORK_WIDTH);
  localparam int RW = $clog2(WORK_WIDTH);
  localparam logic [EXP_WIDTH-1:0] EXP_MAX = {1'b0, {(EXP_WIDTH-1){1'b1}}};

  logic                  s1_valid_q;
  logic [WORK_WIDTH-1:0] s1_val_q;
  logic [EXP_WIDTH-1:0]  s1_exp_q;
  logic                  s2_valid_q;
  logic [RW-1:0]         s1_rsb;
  logic                  s1_adv;
  logic                  s2_adv;
  logic [SW-1:0]         shift_d;
  logic [EXP_WIDTH:0]    exp_sum;
  logic [EXP_WIDTH-1:0]  exp_d;
  logic                  exp_sat_d;

  // S2 moves when it is empty or drained; S1 moves behind it or when empty
  always_comb begin
    s2_adv = !s2_valid_q || out_ready;
    s1_adv = s2_adv || !s1_valid_q;
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;

  lead_sign_count #(
    .WORK_WIDTH(WORK_WIDTH)
  ) u_lead_sign_count (
    .val_i(s1_val_q),
    .rsb_o(s1_rsb)
  );

  // Shift only enough to restore the guard headroom; never shift left
  always_comb begin
    shift_d = '0;
    if (int'(s1_rsb) < GUARD_BITS) begin
      shift_d = SW'(GUARD_BITS - int'(s1_rsb));
    end
    // One extra bit catches overflow past the signed maximum
    exp_sum   = {s1_exp_q[EXP_WIDTH-1], s1_exp_q} + (EXP_WIDTH+1)'(shift_d);
    exp_sat_d = !exp_sum[EXP_WIDTH] && exp_sum[EXP_WIDTH-1];
    exp_d     = exp_sat_d ? EXP_MAX : exp_sum[EXP_WIDTH-1:0];
  end

  // S1: capture the incoming value and exponent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_val_q   <= '0;
      s1_exp_q   <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_val_q <= in_val;
        s1_exp_q <= in_exp;
      end
    end
  end

  // S2: value, shift and exponent register together so they stay aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      val_q       <= '0;
      shift_amt_q <= '0;
      exp_q       <= '0;
      exp_sat_q   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        val_q       <= s1_val_q;
        shift_amt_q <= shift_d;
        exp_q       <= exp_d;
        exp_sat_q   <= exp_sat_d;
      end
    end
  end

`ifdef NORM_SHIFT_STATS_EN
  logic        out_fire;
  logic [31:0] stat_samples_q;
  logic [31:0] stat_shifted_q;
  logic [15:0] stat_exp_sat_q;

  assign out_fire     = s2_valid_q && out_ready;
  assign stat_samples = stat_samples_q;
  assign stat_shifted = stat_shifted_q;
  assign stat_exp_sat = stat_exp_sat_q;

  // Output-transfer counters; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_samples_q <= '0;
      stat_shifted_q <= '0;
      stat_exp_sat_q <= '0;
    end else if (stat_clr) begin
      stat_samples_q <= '0;
      stat_shifted_q <= '0;
      stat_exp_sat_q <= '0;
    end else if (out_fire) begin
      stat_samples_q <= stat_samples_q + 32'd1;
      if (shift_amt_q != '0) begin
        stat_shifted_q <= stat_shifted_q + 32'd1;
      end
      if (exp_sat_q && (stat_exp_sat_q != 16'hFFFF)) begin
        stat_exp_sat_q <= stat_exp_sat_q + 16'd1;
      end
    end
  end
`endif

endmodule
